// File: rtl/page_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// page_sequencer_pkg
// Shared types and constants for the page sequencer:
//   - seq_state_e : sequencer state (RUN, SETTLE)
//   - app_page_t  : page id for the four-page application
//   - APP_ALLOWED : legality mask for that application, bit [from*4+to]
//   - sat_inc16   : saturating 16-bit increment used by the transition counter
// -----------------------------------------------------------------------------
package page_sequencer_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } seq_state_e;

    localparam int APP_PAGES = 4;

    typedef logic [$clog2(APP_PAGES)-1:0] app_page_t;

    localparam int PAGE_INIT    = 0;
    localparam int PAGE_MENU    = 1;
    localparam int PAGE_HISTORY = 2;
    localparam int PAGE_PLAY    = 3;

    // INIT->MENU, MENU<->HISTORY, MENU->PLAY, PLAY->MENU
    localparam logic [APP_PAGES*APP_PAGES-1:0] APP_ALLOWED =
          (16'd1 << (PAGE_INIT    * APP_PAGES + PAGE_MENU))
        | (16'd1 << (PAGE_MENU    * APP_PAGES + PAGE_HISTORY))
        | (16'd1 << (PAGE_HISTORY * APP_PAGES + PAGE_MENU))
        | (16'd1 << (PAGE_MENU    * APP_PAGES + PAGE_PLAY))
        | (16'd1 << (PAGE_PLAY    * APP_PAGES + PAGE_MENU));

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/page_sequencer_tick_down_counter.sv
// -----------------------------------------------------------------------------
// tick_down_counter
// Loadable down-counter that advances only on a tick enable. Reset and load
// both put LOAD_VAL into the counter; a tick decrements it until it reaches
// zero, where it holds.
// Ports:
//   clk     : clock
//   rst_i   : synchronous active-high reset (loads LOAD_VAL)
//   load_i  : load LOAD_VAL (wins over tick_i)
//   tick_i  : decrement enable
//   count_o : current count
//   zero_o  : count is zero
// -----------------------------------------------------------------------------
module tick_down_counter #(
    parameter  int unsigned LOAD_VAL = 2,
    localparam int unsigned CNT_W    = $clog2(LOAD_VAL + 1)
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             tick_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(LOAD_VAL);
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            count_q <= CNT_W'(LOAD_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/page_sequencer.sv
// -----------------------------------------------------------------------------
// page_sequencer
// Holds the current application page, checks each page's requested successor
// against a legality mask, and after reset or any accepted transition holds
// the pages in reset for RST_TICKS program ticks (SETTLE) before accepting
// further requests. The selected page's output bus is registered onto out.
// Ports:
//   clk         : system clock
//   sys_rst     : synchronous active-high reset
//   prog_tick   : one-clk program tick enable
//   page_next   : per-page requested next page, slice i = page i
//   page_out    : per-page output bus, slice i = page i
//   out         : registered output of the current page
//   cur_page    : current page id
//   page_rst    : reset to the pages, high during SETTLE
//   busy        : high during SETTLE
//   illegal_req : one-clk pulse when a request is rejected
//   trans_count : accepted transitions, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module page_sequencer
    import page_sequencer_pkg::*;
#(
    parameter  int unsigned                    N_PAGES   = 4,
    parameter  int unsigned                    OUT_W     = 64,
    parameter  int unsigned                    INIT_PAGE = 0,
    parameter  int unsigned                    RST_TICKS = 2,
    parameter  logic [N_PAGES*N_PAGES-1:0]     ALLOWED   = '1,
    localparam int unsigned                    PAGE_W    = $clog2(N_PAGES)
) (
    input  logic                       clk,
    input  logic                       sys_rst,
    input  logic                       prog_tick,
    input  logic [N_PAGES*PAGE_W-1:0]  page_next,
    input  logic [N_PAGES*OUT_W-1:0]   page_out,
    output logic [OUT_W-1:0]           out,
    output logic [PAGE_W-1:0]          cur_page,
    output logic                       page_rst,
    output logic                       busy,
    output logic                       illegal_req,
    output logic [15:0]                trans_count
);

    localparam int unsigned CNT_W = $clog2(RST_TICKS + 1);

    seq_state_e          state_q, state_d;
    logic [PAGE_W-1:0]   cur_page_q, cur_page_d;
    logic [OUT_W-1:0]    out_q;
    logic                illegal_q, illegal_d;
    logic [15:0]         trans_count_q, trans_count_d;

    logic [PAGE_W-1:0]   req_arr [N_PAGES];
    logic [OUT_W-1:0]    out_arr [N_PAGES];
    logic [N_PAGES*N_PAGES-1:0] legal_hit;
    logic [PAGE_W-1:0]   req;
    logic                req_legal;

    logic                cnt_load, cnt_tick, cnt_zero;
    logic [CNT_W-1:0]    cnt;

    // Per-page slices, and one legality term per (from, to) pair. A request
    // that names no existing page matches no term and is therefore illegal.
    for (genvar f = 0; f < N_PAGES; f++) begin : g_from
        assign req_arr[f] = page_next[f*PAGE_W +: PAGE_W];
        assign out_arr[f] = page_out[f*OUT_W +: OUT_W];
        for (genvar t = 0; t < N_PAGES; t++) begin : g_to
            assign legal_hit[f*N_PAGES+t] = ALLOWED[f*N_PAGES+t]
                                          && (cur_page_q == PAGE_W'(f))
                                          && (req == PAGE_W'(t));
        end
    end

    assign req       = req_arr[cur_page_q];
    assign req_legal = |legal_hit;

    tick_down_counter #(
        .LOAD_VAL (RST_TICKS)
    ) u_settle_cnt (
        .clk     (clk),
        .rst_i   (sys_rst),
        .load_i  (cnt_load),
        .tick_i  (cnt_tick),
        .count_o (cnt),
        .zero_o  (cnt_zero)
    );

    always_comb begin
        state_d       = state_q;
        cur_page_d    = cur_page_q;
        trans_count_d = trans_count_q;
        illegal_d     = 1'b0;
        cnt_load      = 1'b0;
        cnt_tick      = 1'b0;
        case (state_q)
            RUN: begin
                if (prog_tick && (req != cur_page_q)) begin
                    if (req_legal) begin
                        cur_page_d    = req;
                        state_d       = SETTLE;
                        cnt_load      = 1'b1;
                        trans_count_d = sat_inc16(trans_count_q);
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                // Leave on the tick that consumes the last count; an already
                // empty counter also releases so SETTLE can never stick.
                if (prog_tick) begin
                    cnt_tick = 1'b1;
                    if ((cnt == CNT_W'(1)) || cnt_zero) begin
                        state_d = RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q       <= SETTLE;
            cur_page_q    <= PAGE_W'(INIT_PAGE);
            out_q         <= '0;
            illegal_q     <= 1'b0;
            trans_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_page_q    <= cur_page_d;
            out_q         <= out_arr[cur_page_q];
            illegal_q     <= illegal_d;
            trans_count_q <= trans_count_d;
        end
    end

    assign out         = out_q;
    assign cur_page    = cur_page_q;
    assign busy        = (state_q == SETTLE);
    assign page_rst    = busy;
    assign illegal_req = illegal_q;
    assign trans_count = trans_count_q;

endmodule

// File: tb/tb_page_sequencer.sv
module tb_page_sequencer;

    localparam logic [15:0] ALLOWED_A = 16'hFF7F;   // 1->3 forbidden
    localparam logic [7:0]  S  = 8'hE4;              // every page requests itself
    localparam logic [7:0]  RA = 8'hE5;              // page0 -> 1
    localparam logic [7:0]  RB = 8'hE9;              // page0 -> 1, page1 -> 2
    localparam logic [7:0]  RC = 8'hED;              // page0 -> 1, page1 -> 3
    localparam logic [7:0]  RD = 8'hD4;              // page1 -> 1? no: page2 -> 1

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  nxt_a = S;
    logic [31:0] pout_a = 32'h13121110;
    logic [7:0]  out_a;
    logic [1:0]  cur_a;
    logic        prst_a, busy_a, ill_a;
    logic [15:0] tc_a;

    logic [5:0]  nxt_b = 6'h24;
    logic [23:0] pout_b = 24'h121110;
    logic [7:0]  out_b;
    logic [1:0]  cur_b;
    logic        prst_b, busy_b, ill_b;
    logic [15:0] tc_b;

    always #5 clk = ~clk;

    page_sequencer #(
        .N_PAGES(4), .OUT_W(8), .INIT_PAGE(0), .RST_TICKS(2), .ALLOWED(ALLOWED_A)
    ) dut_a (
        .clk(clk), .sys_rst(sys_rst), .prog_tick(tick), .page_next(nxt_a),
        .page_out(pout_a), .out(out_a), .cur_page(cur_a), .page_rst(prst_a),
        .busy(busy_a), .illegal_req(ill_a), .trans_count(tc_a)
    );

    page_sequencer #(
        .N_PAGES(3), .OUT_W(8), .INIT_PAGE(0), .RST_TICKS(2), .ALLOWED(9'h1FF)
    ) dut_b (
        .clk(clk), .sys_rst(sys_rst), .prog_tick(tick), .page_next(nxt_b),
        .page_out(pout_b), .out(out_b), .cur_page(cur_b), .page_rst(prst_b),
        .busy(busy_b), .illegal_req(ill_b), .trans_count(tc_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_a(input string tag, input int pg, input bit prst, input bit ill,
                         input int tc, input logic [7:0] o);
        chk({tag, " cur_page"},    32'(cur_a),  32'(pg));
        chk({tag, " page_rst"},    32'(prst_a), 32'(prst));
        chk({tag, " busy"},        32'(busy_a), 32'(prst));
        chk({tag, " illegal_req"}, 32'(ill_a),  32'(ill));
        chk({tag, " trans_count"}, 32'(tc_a),   32'(tc));
        chk({tag, " out"},         32'(out_a),  32'(o));
    endtask

    // Drive inputs at a falling edge, let one rising edge happen, return at
    // the next falling edge where outputs are stable.
    task automatic step(input bit r, input bit t, input logic [7:0] na);
        sys_rst = r;
        tick    = t;
        nxt_a   = na;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit         rst;
        bit         tick;
        logic [7:0] nxt;
        int         reps;
        int         pg;
        bit         prst;
        bit         ill;
        int         tc;
        logic [7:0] o;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: page, remaining reset ticks, transition count.
    int          m_page, m_left, m_tc;
    bit          m_ill;
    logic [7:0]  m_out;

    function automatic bit allowed_a(input int from, input int to);
        logic [15:0] mask;
        mask = ALLOWED_A;
        return mask[from*4 + to];
    endfunction

    initial begin
        // reset release, ticks every 4th clk
        vecs.push_back('{1'b1, 1'b0, S,  3, 0, 1'b1, 1'b0, 0, 8'h00});
        vecs.push_back('{1'b0, 1'b0, S,  3, 0, 1'b1, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b1, S,  1, 0, 1'b1, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b0, S,  3, 0, 1'b1, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b1, S,  1, 0, 1'b0, 1'b0, 0, 8'h10});
        // legal 0->1; request held without tick is not sampled
        vecs.push_back('{1'b0, 1'b0, RA, 3, 0, 1'b0, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b1, RA, 1, 1, 1'b1, 1'b0, 1, 8'h10});
        // request 1->2 while busy is ignored, taken at first RUN tick
        vecs.push_back('{1'b0, 1'b0, RB, 3, 1, 1'b1, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, RB, 1, 1, 1'b1, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b0, RB, 3, 1, 1'b1, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, RB, 1, 1, 1'b0, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b0, RB, 3, 1, 1'b0, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, RB, 1, 2, 1'b1, 1'b0, 2, 8'h11});
        // reset one clk after 1->2, with a simultaneous tick
        vecs.push_back('{1'b1, 1'b1, RB, 1, 0, 1'b1, 1'b0, 0, 8'h00});
        // tick on the release edge is the first settle tick
        vecs.push_back('{1'b0, 1'b1, S,  1, 0, 1'b1, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b0, S,  3, 0, 1'b1, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b1, S,  1, 0, 1'b0, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b0, RA, 3, 0, 1'b0, 1'b0, 0, 8'h10});
        vecs.push_back('{1'b0, 1'b1, RA, 1, 1, 1'b1, 1'b0, 1, 8'h10});
        // illegal 1->3
        vecs.push_back('{1'b0, 1'b0, RC, 3, 1, 1'b1, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, RC, 1, 1, 1'b1, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b0, RC, 3, 1, 1'b1, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, RC, 1, 1, 1'b0, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b0, RC, 3, 1, 1'b0, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, RC, 1, 1, 1'b0, 1'b1, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b0, RC, 1, 1, 1'b0, 1'b0, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b1, RC, 2, 1, 1'b0, 1'b1, 1, 8'h11});
        vecs.push_back('{1'b0, 1'b0, S,  1, 1, 1'b0, 1'b0, 1, 8'h11});

        @(negedge clk);
        for (int v = 0; v < vecs.size(); v++) begin
            for (int k = 0; k < vecs[v].reps; k++) begin
                step(vecs[v].rst, vecs[v].tick, vecs[v].nxt);
                chk_a($sformatf("vec%0d.%0d", v, k), vecs[v].pg, vecs[v].prst,
                      vecs[v].ill, vecs[v].tc, vecs[v].o);
            end
        end

        // Saturation: preset the count near the top, then three legal moves
        force dut_a.trans_count_q = 16'hFFFE;
        step(1'b0, 1'b0, S);
        release dut_a.trans_count_q;
        chk("sat preset", 32'(tc_a), 32'hFFFE);
        step(1'b0, 1'b1, RB);
        chk_a("sat 1->2", 2, 1'b1, 1'b0, 16'hFFFF, 8'h11);
        step(1'b0, 1'b1, S);
        step(1'b0, 1'b1, S);
        chk_a("sat settle1", 2, 1'b0, 1'b0, 16'hFFFF, 8'h12);
        step(1'b0, 1'b1, RD);
        chk_a("sat 2->1", 1, 1'b1, 1'b0, 16'hFFFF, 8'h12);
        step(1'b0, 1'b1, S);
        step(1'b0, 1'b1, S);
        step(1'b0, 1'b1, RB);
        chk_a("sat 1->2 again", 2, 1'b1, 1'b0, 16'hFFFF, 8'h11);
        step(1'b0, 1'b1, S);
        step(1'b0, 1'b1, S);
        step(1'b0, 1'b0, S);
        chk_a("sat end", 2, 1'b0, 1'b0, 16'hFFFF, 8'h12);

        // Three-page instance: page id 3 does not exist
        nxt_b = 6'b10_01_11;
        step(1'b0, 1'b0, S);
        chk("b no tick ill", 32'(ill_b), 32'd0);
        step(1'b0, 1'b1, S);
        chk("b oor ill", 32'(ill_b), 32'd1);
        chk("b oor page", 32'(cur_b), 32'd0);
        chk("b oor tc", 32'(tc_b), 32'd0);
        chk("b oor busy", 32'(busy_b), 32'd0);
        nxt_b = 6'b10_01_10;
        step(1'b0, 1'b1, S);
        chk("b ill clears", 32'(ill_b), 32'd0);
        chk("b legal page", 32'(cur_b), 32'd2);
        chk("b legal tc", 32'(tc_b), 32'd1);
        nxt_b = 6'h24;

        // Randomized run against the reference model
        m_page = 0; m_left = 2; m_tc = 0; m_ill = 1'b0; m_out = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            bit         r, t;
            int         req;
            logic [7:0] na;
            r  = (c == 0) || ($urandom_range(0, 99) == 0);
            t  = ($urandom_range(0, 2) == 0);
            na = 8'($urandom);
            if ($urandom_range(0, 7) == 0) pout_a = $urandom;
            if (r) begin
                m_page = 0; m_left = 2; m_tc = 0; m_ill = 1'b0; m_out = 8'h00;
            end else begin
                m_out = pout_a[m_page*8 +: 8];
                m_ill = 1'b0;
                if (m_left > 0) begin
                    if (t) m_left--;
                end else if (t) begin
                    req = int'(na[m_page*2 +: 2]);
                    if (req != m_page) begin
                        if (allowed_a(m_page, req)) begin
                            m_page = req;
                            m_left = 2;
                            if (m_tc < 65535) m_tc++;
                        end else begin
                            m_ill = 1'b1;
                        end
                    end
                end
            end
            step(r, t, na);
            chk_a($sformatf("rnd%0d", c), m_page, (m_left > 0), m_ill, m_tc, m_out);
        end

        tick = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
